// File: rtl/sdes_button_conditioner.sv
// Synchronises, debounces and edge-detects active-low pushbuttons; one independent FSM per key.
// Optional auto-repeat of key_press while held is enabled by defining SDES_AUTOREPEAT_EN.
module sdes_button_conditioner #(
    parameter int NUM_KEYS             = 4,
    parameter int DEBOUNCE_CYCLES      = 500_000,
    parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 5_000_000
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY_IN,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ? DEBOUNCE_CYCLES
                                                                     : REPEAT_DELAY_CYCLES;
    localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD_CYCLES) ? MAX_AB : REPEAT_PERIOD_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic             s1_q, s2_q;
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             level_q, level_d;
            logic             press_q, press_d;
            logic             release_q, release_d;

            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    s1_q      <= 1'b1;
                    s2_q      <= 1'b1;
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    level_q   <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    s1_q      <= KEY_IN[gi];
                    s2_q      <= s1_q;
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    level_q   <= level_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                end
            end

`ifdef SDES_AUTOREPEAT_EN
            localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
            localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

            // rep_first_q selects the initial delay until the first repeat has fired.
            logic [CNT_W-1:0] rep_q, rep_d;
            logic             rep_first_q, rep_first_d;

            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    rep_q       <= '0;
                    rep_first_q <= 1'b1;
                end else begin
                    rep_q       <= rep_d;
                    rep_first_q <= rep_first_d;
                end
            end
`endif

            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                level_d   = level_q;
                press_d   = 1'b0;
                release_d = 1'b0;
`ifdef SDES_AUTOREPEAT_EN
                rep_d       = rep_q;
                rep_first_d = rep_first_q;
`endif
                case (state_q)
                    IDLE: begin
                        if (!s2_q) begin
                            state_d = PRESS_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (s2_q) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            level_d = 1'b1;
                            press_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (s2_q) begin
                            state_d = RELEASE_WAIT;
                            cnt_d   = '0;
                        end else begin
`ifdef SDES_AUTOREPEAT_EN
                            if (rep_q == (rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
                                press_d     = 1'b1;
                                rep_d       = '0;
                                rep_first_d = 1'b0;
                            end else begin
                                rep_d = rep_q + CNT_ONE;
                            end
`endif
                        end
                    end
                    RELEASE_WAIT: begin
                        // A bounce back to pressed keeps the repeat schedule where it was.
                        if (!s2_q) begin
                            state_d = HELD;
                            cnt_d   = '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            level_d   = 1'b0;
                            release_d = 1'b1;
`ifdef SDES_AUTOREPEAT_EN
                            rep_d       = '0;
                            rep_first_d = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign key_level[gi]   = level_q;
            assign key_press[gi]   = press_q;
            assign key_release[gi] = release_q;
        end
    endgenerate

endmodule

// File: tb/tb_sdes_button_conditioner.sv
// Scoreboard bench for sdes_button_conditioner: stimulus queues expected pulse events,
// a negedge monitor pops and compares whenever a press/release pulse appears.
module tb_sdes_button_conditioner;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] key_in = 4'hF;
    logic [3:0] lvl, prs, rls;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         c;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] l;
    } ev_t;

    ev_t q[$];
    ev_t mon_ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdes_button_conditioner #(
        .NUM_KEYS            (4),
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (10),
        .REPEAT_PERIOD_CYCLES(3)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .KEY_IN     (key_in),
        .key_level  (lvl),
        .key_press  (prs),
        .key_release(rls)
    );

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l);
        ev_t e;
        e.c = c;
        e.p = p;
        e.r = r;
        e.l = l;
        q.push_back(e);
    endtask

    // Auto-repeat pulses for a continuous hold: first at press+10, then every 3 cycles,
    // up to the last cycle the FSM still sees the key low.
    task automatic push_repeats(input int pc, input int last, input logic [3:0] m,
                                input logic [3:0] l);
        int t2;
        t2 = pc + 10;
`ifndef SDES_AUTOREPEAT_EN
        t2 = last + 1;
`endif
        while (t2 <= last) begin
            push_ev(t2, m, 4'b0000, l);
            t2 += 3;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].c < cyc) begin
            mon_ev = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_event: no pulse at cycle %0d, expected press=%b release=%b",
                     mon_ev.c, mon_ev.p, mon_ev.r);
        end
        if ((prs | rls) !== 4'b0000) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: press=%b release=%b at cycle %0d, expected none",
                         prs, rls, cyc);
            end else begin
                mon_ev = q.pop_front();
                check_int("ev_cycle", cyc, mon_ev.c);
                check4("ev_press", prs, mon_ev.p);
                check4("ev_release", rls, mon_ev.r);
                check4("ev_level", lvl, mon_ev.l);
                $display("event cycle=%0d press=%b release=%b level=%b", cyc, prs, rls, lvl);
            end
        end
    end

    initial begin
        int t;
        #2;
        rst_n  = 1'b0;
        key_in = 4'b0000;
        repeat (3) tick();
        check4("reset_level", lvl, 4'b0000);
        check4("reset_press", prs, 4'b0000);
        check4("reset_release", rls, 4'b0000);

        // All keys held through reset: fresh press after deassertion.
        rst_n = 1'b1;
        t = cyc;
        push_ev(t + 7, 4'b1111, 4'b0000, 4'b1111);
        push_repeats(t + 7, t + 14, 4'b1111, 4'b1111);
        push_ev(t + 19, 4'b0000, 4'b1111, 4'b0000);
        wait_until(t + 12);
        key_in = 4'b1111;
        wait_until(t + 25);
        check4("all_release_level", lvl, 4'b0000);

        // Clean press and release on key 0.
        t = cyc;
        key_in = 4'b1110;
        push_ev(t + 7, 4'b0001, 4'b0000, 4'b0001);
        push_repeats(t + 7, t + 22, 4'b0001, 4'b0001);
        push_ev(t + 27, 4'b0000, 4'b0001, 4'b0000);
        wait_until(t + 10);
        check4("clean_press_level", lvl, 4'b0001);
        wait_until(t + 20);
        key_in = 4'b1111;
        wait_until(t + 30);
        check4("clean_release_level", lvl, 4'b0000);

        // Press bounce on key 1: two 3-cycle lows never reach the debounce count.
        t = cyc;
        key_in = 4'b1101;
        wait_until(t + 3);
        key_in = 4'b1111;
        wait_until(t + 4);
        key_in = 4'b1101;
        wait_until(t + 7);
        key_in = 4'b1111;
        wait_until(t + 20);
        check4("bounce_level", lvl, 4'b0000);

        // Release bounce on key 2 while held.
        t = cyc;
        key_in = 4'b1011;
        push_ev(t + 7, 4'b0100, 4'b0000, 4'b0100);
        push_ev(t + 23, 4'b0000, 4'b0100, 4'b0000);
        wait_until(t + 12);
        key_in = 4'b1111;
        wait_until(t + 14);
        key_in = 4'b1011;
        wait_until(t + 16);
        check4("release_bounce_level", lvl, 4'b0100);
        key_in = 4'b1111;
        wait_until(t + 30);
        check4("release_after_bounce_level", lvl, 4'b0000);

        // Reset mid-PRESS_WAIT, then mid-HELD.
        t = cyc;
        key_in = 4'b1110;
        wait_until(t + 4);
        rst_n = 1'b0;
        #1;
        check4("rst_pw_level", lvl, 4'b0000);
        check4("rst_pw_press", prs, 4'b0000);
        check4("rst_pw_release", rls, 4'b0000);
        tick();
        tick();
        rst_n = 1'b1;
        t = cyc;
        push_ev(t + 7, 4'b0001, 4'b0000, 4'b0001);
        wait_until(t + 10);
        check4("rehold_level", lvl, 4'b0001);
        rst_n = 1'b0;
        #1;
        check4("rst_held_level", lvl, 4'b0000);
        check4("rst_held_release", rls, 4'b0000);
        key_in = 4'b1111;
        tick();
        tick();
        rst_n = 1'b1;
        wait_until(t + 30);
        check4("post_reset_level", lvl, 4'b0000);

        // Long hold on key 3 (auto-repeat when enabled).
        t = cyc;
        key_in = 4'b0111;
        push_ev(t + 7, 4'b1000, 4'b0000, 4'b1000);
        push_repeats(t + 7, t + 32, 4'b1000, 4'b1000);
        push_ev(t + 37, 4'b0000, 4'b1000, 4'b0000);
        wait_until(t + 20);
        check4("long_hold_level", lvl, 4'b1000);
        wait_until(t + 30);
        key_in = 4'b1111;
        wait_until(t + 45);
        check4("long_release_level", lvl, 4'b0000);

        check_int("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
